// File: rtl/hwpe_ctrl_offloader.sv
// hwpe_ctrl_offloader: initiator side of the HWPE periph control port.
// Acquires a context, streams job registers, triggers, awaits done.
module hwpe_ctrl_offloader #(
  parameter int unsigned ID_WIDTH = 16,
  parameter int unsigned REGFILE_N_EVT = 2,
  parameter int unsigned REGFILE_N_MANDATORY_REGS = 7,
  parameter int unsigned REGFILE_N_RESERVED_REGS = 1,
  parameter int unsigned REGFILE_MANDATORY_TRIGGER = 0,
  parameter int unsigned REGFILE_MANDATORY_ACQUIRE = 1,
  parameter int unsigned REGFILE_MANDATORY_SOFTCLEAR = 5,
  parameter int unsigned LOG_CONTEXT = 1,
  parameter int unsigned N_EVT = REGFILE_N_EVT,
  parameter int unsigned N_JOB_REGS = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned FIRST_JOB_REG =
    REGFILE_N_MANDATORY_REGS + REGFILE_N_RESERVED_REGS,
  parameter int unsigned MASTER_ID = 1,
  parameter int unsigned BACKOFF_CYCLES = 8,
  localparam int unsigned NREG_W = $clog2(N_JOB_REGS + 1),
  localparam int unsigned IDX_W = $clog2(N_JOB_REGS),
  localparam int unsigned CTX_W = (LOG_CONTEXT > 1) ? LOG_CONTEXT : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                job_valid_i,
  output logic                job_ready_o,
  input  logic [NREG_W-1:0]   job_nregs_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [31:0]         wr_data_i,
  input  logic                abort_i,
  input  logic [N_EVT-1:0]    evt_i,
  output logic                busy_o,
  output logic [CTX_W-1:0]    ctx_o,
  output logic                done_o,
  output logic                periph_req_o,
  input  logic                periph_gnt_i,
  output logic [31:0]         periph_add_o,
  output logic                periph_wen_o,
  output logic [3:0]          periph_be_o,
  output logic [31:0]         periph_data_o,
  output logic [ID_WIDTH-1:0] periph_id_o,
  input  logic [31:0]         periph_r_data_i,
  input  logic                periph_r_valid_i,
  input  logic [ID_WIDTH-1:0] periph_r_id_i
);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] ACQ        = 4'd1;
  localparam logic [3:0] ACQ_WAIT   = 4'd2;
  localparam logic [3:0] BACKOFF    = 4'd3;
  localparam logic [3:0] PROG       = 4'd4;
  localparam logic [3:0] TRIG       = 4'd5;
  localparam logic [3:0] WAIT_EVT   = 4'd6;
  localparam logic [3:0] CLEAR      = 4'd7;
  localparam logic [3:0] CLEAR_WAIT = 4'd8;

  localparam int unsigned TMR_W = $clog2(BACKOFF_CYCLES + 4);
  localparam logic [ID_WIDTH-1:0] MID = ID_WIDTH'(MASTER_ID);

  function automatic logic [31:0] reg_addr(input logic [31:0] idx);
    return BASE_ADDR + (idx << 2);
  endfunction

  logic [3:0]        state_q, state_d;
  logic              req_q, wen_q;
  logic [31:0]       add_q, data_q;
  logic              launch, l_wen;
  logic [31:0]       l_add, l_data;
  logic              go_acq, go_trig, go_clear;
  logic [NREG_W-1:0] nregs_q, nregs_d;
  logic [NREG_W-1:0] beat_q, beat_d, beat_inc;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CTX_W-1:0]  ctx_q, ctx_d;
  logic              abort_q, abort_d, abort_any;
  logic              done_q, done_d, active_q;
  logic              hs, rsp, unused_bits;

  assign hs        = req_q & periph_gnt_i;
  assign rsp       = periph_r_valid_i & (periph_r_id_i == MID);
  assign abort_any = abort_q | abort_i;
  assign beat_inc  = beat_q + NREG_W'(1);

  always_comb begin
    state_d  = state_q;
    nregs_d  = nregs_q;
    beat_d   = beat_q;
    tmr_d    = tmr_q;
    ctx_d    = ctx_q;
    done_d   = 1'b0;
    abort_d  = abort_any;
    go_acq   = 1'b0;
    go_trig  = 1'b0;
    go_clear = 1'b0;
    launch   = 1'b0;
    l_add    = '0;
    l_wen    = 1'b0;
    l_data   = '0;
    unique case (state_q)
      IDLE: begin
        if (abort_any) begin
          go_clear = 1'b1;
        end else if (job_valid_i && active_q) begin
          go_acq  = 1'b1;
          nregs_d = job_nregs_i;
          beat_d  = '0;
        end
      end
      ACQ: begin
        if (hs) state_d = ACQ_WAIT;
      end
      ACQ_WAIT: begin
        if (rsp) begin
          if (periph_r_data_i[31]) begin
            tmr_d = '0;
            if (abort_any) go_clear = 1'b1;
            else state_d = BACKOFF;
          end else begin
            ctx_d = periph_r_data_i[CTX_W-1:0];
            if (abort_any) go_clear = 1'b1;
            else if (nregs_q == '0) go_trig = 1'b1;
            else state_d = PROG;
          end
        end
      end
      BACKOFF: begin
        if (abort_any) go_clear = 1'b1;
        else if (tmr_q == TMR_W'(BACKOFF_CYCLES - 1)) go_acq = 1'b1;
        else tmr_d = tmr_q + TMR_W'(1);
      end
      PROG: begin
        if (req_q) begin
          if (periph_gnt_i) begin
            beat_d = beat_inc;
            if (abort_any) go_clear = 1'b1;
            else if (beat_inc == nregs_q) go_trig = 1'b1;
          end
        end else if (abort_any) begin
          go_clear = 1'b1;
        end else if (wr_valid_i) begin
          launch = 1'b1;
          l_add  = reg_addr(32'(FIRST_JOB_REG) + 32'(wr_idx_i));
          l_data = wr_data_i;
        end
      end
      TRIG: begin
        if (hs) begin
          if (abort_any) go_clear = 1'b1;
          else state_d = WAIT_EVT;
        end
      end
      WAIT_EVT: begin
        if (abort_any) begin
          go_clear = 1'b1;
        end else if (evt_i[0]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      CLEAR: begin
        abort_d = 1'b0;
        if (hs) begin
          state_d = CLEAR_WAIT;
          tmr_d   = '0;
          ctx_d   = '0;
        end
      end
      CLEAR_WAIT: begin
        // hold off long enough to cover the slave's clear pulse
        abort_d = 1'b0;
        if (tmr_q == TMR_W'(3)) state_d = IDLE;
        else tmr_d = tmr_q + TMR_W'(1);
      end
      default: state_d = IDLE;
    endcase
    unique case (1'b1)
      go_clear: begin
        state_d = CLEAR;
        launch  = 1'b1;
        l_add   = reg_addr(32'(REGFILE_MANDATORY_SOFTCLEAR));
        abort_d = 1'b0;
      end
      go_trig: begin
        state_d = TRIG;
        launch  = 1'b1;
        l_add   = reg_addr(32'(REGFILE_MANDATORY_TRIGGER));
      end
      go_acq: begin
        state_d = ACQ;
        launch  = 1'b1;
        l_wen   = 1'b1;
        l_add   = reg_addr(32'(REGFILE_MANDATORY_ACQUIRE));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      wen_q    <= 1'b1;
      add_q    <= '0;
      data_q   <= '0;
      nregs_q  <= '0;
      beat_q   <= '0;
      tmr_q    <= '0;
      ctx_q    <= '0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      nregs_q  <= nregs_d;
      beat_q   <= beat_d;
      tmr_q    <= tmr_d;
      ctx_q    <= ctx_d;
      abort_q  <= abort_d;
      done_q   <= done_d;
      active_q <= 1'b1;
      if (launch) begin
        req_q  <= 1'b1;
        add_q  <= l_add;
        wen_q  <= l_wen;
        data_q <= l_data;
      end else if (hs) begin
        req_q  <= 1'b0;
      end
    end
  end

  assign job_ready_o = active_q & (state_q == IDLE) & ~abort_any;
  assign wr_ready_o  = (state_q == PROG) & hs;
  assign busy_o      = (state_q != IDLE) & (state_q != CLEAR_WAIT);
  assign ctx_o       = ctx_q;
  assign done_o      = done_q;

  assign periph_req_o  = req_q;
  assign periph_add_o  = add_q;
  assign periph_wen_o  = wen_q;
  assign periph_be_o   = 4'hF;
  assign periph_data_o = data_q;
  assign periph_id_o   = MID;

  assign unused_bits = ^{evt_i, periph_r_data_i};

endmodule
